// File: rtl/pipelined_adder.sv
// WIDTH-bit adder whose carry chain is cut into STAGES equal chunks, one register stage per chunk.
// Valid/ready on both sides; a single global stall freezes every stage while the output is blocked.
module pipelined_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int C = WIDTH / STAGES;
    localparam int L = STAGES - 1;

    if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("pipelined_adder: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
    end

    // Register after stage k: operand skew, partial sum, carry out of chunk k, valid.
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic             c_q   [STAGES];
    logic             v_q   [STAGES];
    logic             ovf_q;

    logic [WIDTH-1:0] a_src [STAGES];
    logic [WIDTH-1:0] b_src [STAGES];
    logic [WIDTH-1:0] s_src [STAGES];
    logic             c_src [STAGES];
    logic             v_src [STAGES];
    logic [WIDTH-1:0] s_nxt [STAGES];
    logic             c_nxt [STAGES];
    logic [C:0]       chunk [STAGES];
    logic             ovf_nxt;
    logic             stall;

    always_comb begin
        a_src[0] = a;
        b_src[0] = b;
        s_src[0] = '0;
        c_src[0] = carry_in;
        v_src[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_src[k] = a_q[k-1];
            b_src[k] = b_q[k-1];
            s_src[k] = s_q[k-1];
            c_src[k] = c_q[k-1];
            v_src[k] = v_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            chunk[k] = {1'b0, a_src[k][k*C +: C]} + {1'b0, b_src[k][k*C +: C]}
                     + {{C{1'b0}}, c_src[k]};
            s_nxt[k] = s_src[k];
            s_nxt[k][k*C +: C] = chunk[k][C-1:0];
            c_nxt[k] = chunk[k][C];
        end
        // a^b^s at the MSB recovers the carry into the top bit without exposing the chain.
        ovf_nxt = a_src[L][WIDTH-1] ^ b_src[L][WIDTH-1] ^ s_nxt[L][WIDTH-1] ^ c_nxt[L];
    end

    assign stall = v_q[L] & ~out_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_src[k];
                b_q[k] <= b_src[k];
                s_q[k] <= s_nxt[k];
                c_q[k] <= c_nxt[k];
                v_q[k] <= v_src[k];
            end
            ovf_q <= ovf_nxt;
        end
    end

    assign in_ready  = ~stall;
    assign sum       = s_q[L];
    assign carry_out = c_q[L];
    assign overflow  = ovf_q;
    assign out_valid = v_q[L];
endmodule
